// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution sequencer: FSM state encoding and
// the fixed depth of the SP-read -> reg1 -> reg2 -> reg3 MAC pipeline.
package conv_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FILL,
      SETUP,
      MAC,
      DRAIN,
      EMIT,
      WAIT_WR,
      ADVANCE,
      SETUP_NEXT,
      DONE
   } state_e;

   localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/conv_controller_valid_pipe.sv
// Valid shifter that follows each MAC issue through reg1..reg3; bit k drives
// the load enable of pipeline register k+1.
module mac_valid_pipe #(
   parameter int DEPTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             issue_i,
   output logic [DEPTH-1:0] vld_o,
   output logic             pipe_empty_o
);

   logic [DEPTH-1:0] v_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v_q <= '0;
      end else begin
         v_q <= {v_q[DEPTH-2:0], issue_i};
      end
   end

   assign vld_o = v_q;

   // High when, with no new issue, the pipe holds nothing after the coming edge:
   // only the last stage may still be loading reg3 this cycle.
   assign pipe_empty_o = ~|v_q[DEPTH-2:0];

endmodule

// File: rtl/conv_controller.sv
// Top-level sequencer for the convolution datapath: scratchpad fill, window x
// filter MAC loops, drain, and the handshake with the output write controller.
module conv_controller #(
   parameter int STRIDE_SIZE  = 2,
   parameter int FILTER_SIZE  = 4,
   parameter int DRAIN_CYCLES = conv_ctrl_pkg::DRAIN_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [STRIDE_SIZE-1:0] cfg_stride,
   input  logic [FILTER_SIZE-1:0] cfg_filter_size,
   input  logic                   IF_done,
   input  logic                   Filter_done,
   input  logic                   row_end,
   input  logic                   finish_row,
   input  logic                   filter_end,
   input  logic                   finish_filter,
   input  logic                   write_done,
   output logic [STRIDE_SIZE-1:0] stride_in,
   output logic [FILTER_SIZE-1:0] filter_size,
   output logic                   IF_read_cntrl_en,
   output logic                   Filter_read_cntrl__en,
   output logic                   clr_If,
   output logic                   clr_Filter,
   output logic                   clr_out,
   output logic                   ld_row_ptr,
   output logic                   clr_row_ptr,
   output logic                   row_ptr_cnt_en,
   output logic                   ld_input_head,
   output logic                   sel,
   output logic                   ld_filter_head,
   output logic                   clr_filter_head,
   output logic                   filter_cnt_en,
   output logic                   index_cnt_en,
   output logic                   clr_index,
   output logic                   filter_ren,
   output logic                   chip_en,
   output logic                   ld1,
   output logic                   ld2,
   output logic                   ld3,
   output logic                   clr1,
   output logic                   clr2,
   output logic                   clr3,
   output logic                   conv_done,
   output logic                   busy,
   output logic                   done
);

   import conv_ctrl_pkg::*;

   state_e                   state_q;
   logic [STRIDE_SIZE-1:0]   stride_q;
   logic [FILTER_SIZE-1:0]   fsize_q;
   logic                     if_seen_q;
   logic                     flt_seen_q;
   logic                     clr_start_q;
   logic                     if_ok;
   logic                     flt_ok;
   logic                     issue;
   logic                     pipe_empty;
   logic [DRAIN_CYCLES-1:0]  vld;

   assign if_ok  = if_seen_q | IF_done;
   assign flt_ok = flt_seen_q | Filter_done;
   assign issue  = (state_q == MAC);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         stride_q    <= '0;
         fsize_q     <= '0;
         if_seen_q   <= 1'b0;
         flt_seen_q  <= 1'b0;
         clr_start_q <= 1'b0;
      end else begin
         clr_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= FILL;
                  stride_q    <= cfg_stride;
                  fsize_q     <= cfg_filter_size;
                  if_seen_q   <= 1'b0;
                  flt_seen_q  <= 1'b0;
                  clr_start_q <= 1'b1;
               end
            end
            FILL: begin
               // The two fills finish independently; remember each completion.
               if_seen_q  <= if_ok;
               flt_seen_q <= flt_ok;
               if (if_ok && flt_ok) state_q <= SETUP;
            end
            SETUP:      state_q <= MAC;
            MAC:        if (filter_end) state_q <= DRAIN;
            DRAIN:      if (pipe_empty) state_q <= EMIT;
            EMIT:       state_q <= WAIT_WR;
            WAIT_WR:    if (write_done) state_q <= ADVANCE;
            ADVANCE:    state_q <= (finish_filter && finish_row) ? DONE : SETUP_NEXT;
            SETUP_NEXT: state_q <= MAC;
            DONE: begin
               state_q  <= IDLE;
               stride_q <= '0;
               fsize_q  <= '0;
            end
            default:    state_q <= IDLE;
         endcase
      end
   end

   mac_valid_pipe #(
      .DEPTH(DRAIN_CYCLES)
   ) u_valid_pipe (
      .clk_i       (clk),
      .rst_ni      (rst),
      .issue_i     (issue),
      .vld_o       (vld),
      .pipe_empty_o(pipe_empty)
   );

   assign ld1         = vld[0];
   assign ld2         = vld[1];
   assign ld3         = vld[2];
   assign stride_in   = stride_q;
   assign filter_size = fsize_q;
   assign busy        = (state_q != IDLE);

   always_comb begin
      IF_read_cntrl_en      = 1'b0;
      Filter_read_cntrl__en = 1'b0;
      clr_If                = clr_start_q;
      clr_Filter            = clr_start_q;
      clr_out               = clr_start_q;
      clr_row_ptr           = clr_start_q;
      clr_filter_head       = clr_start_q;
      clr_index             = clr_start_q;
      ld_row_ptr            = 1'b0;
      row_ptr_cnt_en        = 1'b0;
      ld_input_head         = 1'b0;
      sel                   = 1'b0;
      ld_filter_head        = 1'b0;
      filter_cnt_en         = 1'b0;
      index_cnt_en          = 1'b0;
      filter_ren            = 1'b0;
      chip_en               = 1'b0;
      clr1                  = 1'b0;
      clr2                  = 1'b0;
      clr3                  = 1'b0;
      conv_done             = 1'b0;
      done                  = 1'b0;
      case (state_q)
         FILL: begin
            IF_read_cntrl_en      = !if_seen_q;
            Filter_read_cntrl__en = !flt_seen_q;
         end
         SETUP: begin
            ld_row_ptr    = 1'b1;
            ld_input_head = 1'b1;
            clr_index     = 1'b1;
            clr1          = 1'b1;
            clr2          = 1'b1;
            clr3          = 1'b1;
         end
         MAC: begin
            filter_ren   = 1'b1;
            chip_en      = 1'b1;
            index_cnt_en = 1'b1;
         end
         EMIT: conv_done = 1'b1;
         ADVANCE: begin
            // Last filter of a window slides the input head by the stride;
            // otherwise step to the next filter over the same window.
            if (!(finish_filter && finish_row)) begin
               if (finish_filter) begin
                  clr_filter_head = 1'b1;
                  sel             = 1'b1;
                  ld_input_head   = 1'b1;
                  row_ptr_cnt_en  = row_end;
               end else begin
                  ld_filter_head = 1'b1;
                  filter_cnt_en  = 1'b1;
               end
            end
         end
         SETUP_NEXT: begin
            clr_index = 1'b1;
            clr3      = 1'b1;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_conv_controller.sv
// Self-checking bench for conv_controller: table of jobs plus reset and
// busy-start sequences, with a queue of expected conv_done results.
module tb_conv_controller;

   localparam int SW = 2;
   localparam int FW = 4;

   typedef struct {
      int n; int stride; int if_dly; int flt_dly; int wr_dly;
      int nf; int nw; int rowend;
      int exp_conv; int exp_slides; int exp_fadv; int exp_rowinc; int exp_lat;
      int poke;
   } vec_t;

   typedef struct { int n; int lat; } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [SW-1:0] cfg_stride = '0;
   logic [FW-1:0] cfg_filter_size = '0;
   logic IF_done = 1'b0, Filter_done = 1'b0, row_end = 1'b0, finish_row = 1'b0;
   logic filter_end = 1'b0, finish_filter = 1'b0, write_done = 1'b0;
   logic [SW-1:0] stride_in;
   logic [FW-1:0] filter_size;
   logic IF_read_cntrl_en, Filter_read_cntrl__en, clr_If, clr_Filter, clr_out;
   logic ld_row_ptr, clr_row_ptr, row_ptr_cnt_en, ld_input_head, sel;
   logic ld_filter_head, clr_filter_head, filter_cnt_en, index_cnt_en, clr_index;
   logic filter_ren, chip_en, ld1, ld2, ld3, clr1, clr2, clr3, conv_done, busy, done;
   logic [24:0] ctl;

   assign ctl = {IF_read_cntrl_en, Filter_read_cntrl__en, clr_If, clr_Filter, clr_out,
                 ld_row_ptr, clr_row_ptr, row_ptr_cnt_en, ld_input_head, sel,
                 ld_filter_head, clr_filter_head, filter_cnt_en, index_cnt_en, clr_index,
                 filter_ren, chip_en, ld1, ld2, ld3, clr1, clr2, clr3, conv_done, done};

   conv_controller #(.STRIDE_SIZE(SW), .FILTER_SIZE(FW), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_stride(cfg_stride),
      .cfg_filter_size(cfg_filter_size), .IF_done(IF_done), .Filter_done(Filter_done),
      .row_end(row_end), .finish_row(finish_row), .filter_end(filter_end),
      .finish_filter(finish_filter), .write_done(write_done),
      .stride_in(stride_in), .filter_size(filter_size),
      .IF_read_cntrl_en(IF_read_cntrl_en), .Filter_read_cntrl__en(Filter_read_cntrl__en),
      .clr_If(clr_If), .clr_Filter(clr_Filter), .clr_out(clr_out),
      .ld_row_ptr(ld_row_ptr), .clr_row_ptr(clr_row_ptr), .row_ptr_cnt_en(row_ptr_cnt_en),
      .ld_input_head(ld_input_head), .sel(sel), .ld_filter_head(ld_filter_head),
      .clr_filter_head(clr_filter_head), .filter_cnt_en(filter_cnt_en),
      .index_cnt_en(index_cnt_en), .clr_index(clr_index), .filter_ren(filter_ren),
      .chip_en(chip_en), .ld1(ld1), .ld2(ld2), .ld3(ld3), .clr1(clr1), .clr2(clr2),
      .clr3(clr3), .conv_done(conv_done), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   // job parameters and bench-side generator model
   int cur_n = 1, cur_nf = 1, cur_nw = 1, cur_rowend = 0, cur_if = 1, cur_flt = 1;
   int cur_wr = 1, cur_stride = 0, start_cyc = 0;
   bit job_active = 0;
   int idx = 0, fcnt = 0, wcnt = 0;
   int if_en_cnt, flt_en_cnt, clr_cnt, slide_cnt, lih_cnt, fadv_cnt, rowinc_cnt;
   int conv_cnt, done_cnt, setup_cyc;
   int mark = 0, w_ice = 0, w_l1 = 0, w_l2 = 0, w_l3 = 0, first_l1 = -1, first_l3 = -1;
   int wr_due = -1;
   bit wait_active = 0, noisy = 0;
   exp_t sb[$];

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         filter_end    = (idx == cur_n - 1);
         finish_filter = (fcnt == cur_nf - 1);
         finish_row    = (wcnt == cur_nw - 1);
         row_end       = (cur_rowend != 0);
         IF_done       = job_active && (cyc >= start_cyc + cur_if);
         Filter_done   = job_active && (cyc >= start_cyc + cur_flt);
         write_done    = (cyc == wr_due);
         #1;
         if (rst) begin
            if (clr_index) idx = 0;
            if (index_cnt_en) idx++;
            if (clr_filter_head) fcnt = 0;
            if (ld_filter_head) fcnt++;
            if (clr_row_ptr) wcnt = 0;
            if (ld_input_head && sel) wcnt++;
            if_en_cnt  += int'(IF_read_cntrl_en);
            flt_en_cnt += int'(Filter_read_cntrl__en);
            clr_cnt    += int'(clr_If & clr_Filter & clr_out & clr_row_ptr & clr_filter_head & clr_index);
            slide_cnt  += int'(ld_input_head & sel);
            lih_cnt    += int'(ld_input_head);
            fadv_cnt   += int'(ld_filter_head & filter_cnt_en);
            rowinc_cnt += int'(row_ptr_cnt_en);
            if (clr_index && (clr1 || clr3)) begin
               mark = cyc; w_ice = 0; w_l1 = 0; w_l2 = 0; w_l3 = 0;
               first_l1 = -1; first_l3 = -1;
               if (clr1 && setup_cyc < 0) begin
                  setup_cyc = cyc;
                  check("cfg_stride", int'(stride_in), cur_stride);
                  check("cfg_fsize", int'(filter_size), cur_n);
               end
            end
            if (index_cnt_en && filter_ren && chip_en) w_ice++;
            if (ld1) begin w_l1++; if (first_l1 < 0) first_l1 = cyc; end
            if (ld2) w_l2++;
            if (ld3) begin w_l3++; if (first_l3 < 0) first_l3 = cyc; end
            if (wait_active) begin
               if (ctl != 0) noisy = 1;
               if (cyc == wr_due) begin
                  check("wait_quiet", int'(noisy), 0);
                  wait_active = 0;
               end
            end
            if (conv_done) begin
               conv_cnt++;
               if (sb.size() == 0) check("conv_unexpected", 1, 0);
               else begin
                  e = sb.pop_front();
                  check("conv_latency", cyc - mark, e.lat);
                  check("mac_issues", w_ice, e.n);
                  check("ld1_cycles", w_l1, e.n);
                  check("ld2_cycles", w_l2, e.n);
                  check("ld3_cycles", w_l3, e.n);
                  check("ld1_first", first_l1 - mark, 2);
                  check("ld3_first", first_l3 - mark, 4);
               end
               wr_due = cyc + cur_wr;
               wait_active = 1;
               noisy = 0;
            end
            if (done) done_cnt++;
         end
      end
   end

   task automatic launch(input vec_t v);
      @(negedge clk);
      cur_n = v.n; cur_nf = v.nf; cur_nw = v.nw; cur_rowend = v.rowend;
      cur_if = v.if_dly; cur_flt = v.flt_dly; cur_wr = v.wr_dly; cur_stride = v.stride;
      if_en_cnt = 0; flt_en_cnt = 0; clr_cnt = 0; slide_cnt = 0; lih_cnt = 0;
      fadv_cnt = 0; rowinc_cnt = 0; conv_cnt = 0; done_cnt = 0; setup_cyc = -1;
      wait_active = 0;
      sb.delete();
      for (int k = 0; k < v.exp_conv; k++) sb.push_back('{v.n, v.exp_lat});
      cfg_stride = SW'(v.stride);
      cfg_filter_size = FW'(v.n);
      start = 1'b1;
      start_cyc = cyc;
      job_active = 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_job(input vec_t v);
      int t;
      int fill;
      launch(v);
      if (v.poke != 0) begin
         repeat (2) @(negedge clk);
         cfg_stride = SW'(v.stride + 1);
         cfg_filter_size = FW'(v.n + 5);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         #2;
         check("poke_stride", int'(stride_in), v.stride);
         check("poke_fsize", int'(filter_size), v.n);
         check("poke_busy", int'(busy), 1);
      end
      t = 0;
      while (done_cnt == 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", int'(done_cnt != 0), 1);
      repeat (3) @(negedge clk);
      #2;
      job_active = 0;
      fill = (v.if_dly > v.flt_dly) ? v.if_dly : v.flt_dly;
      check("setup_cycle", setup_cyc - start_cyc, fill + 1);
      check("if_en_cycles", if_en_cnt, v.if_dly);
      check("flt_en_cycles", flt_en_cnt, v.flt_dly);
      check("start_clears", clr_cnt, 1);
      check("conv_count", conv_cnt, v.exp_conv);
      check("sb_left", sb.size(), 0);
      check("slides", slide_cnt, v.exp_slides);
      check("ld_input_head", lih_cnt, v.exp_slides + 1);
      check("filter_adv", fadv_cnt, v.exp_fadv);
      check("row_inc", rowinc_cnt, v.exp_rowinc);
      check("done_pulses", done_cnt, 1);
      check("idle_quiet", int'(ctl != 0 || busy || stride_in != 0 || filter_size != 0), 0);
   endtask

   vec_t vecs[6];
   vec_t rv;

   initial begin : main
      int t;
      //           n  st if fl wr nf nw re conv sl fadv rinc lat poke
      vecs[0] = '{4, 1, 3, 7, 1, 1, 1, 0, 1,   0, 0,   0,   8,  0};
      vecs[1] = '{1, 2, 1, 1, 2, 1, 1, 0, 1,   0, 0,   0,   5,  0};
      vecs[2] = '{3, 1, 2, 2, 10, 1, 1, 0, 1,  0, 0,   0,   7,  0};
      vecs[3] = '{2, 3, 5, 2, 1, 2, 3, 1, 6,   2, 3,   2,   6,  0};
      vecs[4] = '{1, 1, 1, 4, 3, 3, 2, 0, 6,   1, 4,   0,   5,  0};
      vecs[5] = '{2, 2, 6, 6, 1, 1, 1, 0, 1,   0, 0,   0,   6,  1};
      rv      = '{8, 1, 1, 1, 1, 1, 1, 0, 1,   0, 0,   0,  12,  0};

      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("reset_state", int'(ctl != 0 || busy || stride_in != 0 || filter_size != 0), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      check("idle_after_reset", int'(ctl != 0 || busy), 0);

      // asynchronous reset during the fifth MAC cycle
      launch(rv);
      t = 0;
      while (!(w_ice == 4 && setup_cyc >= 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("reach_mac5", int'(t < 200), 1);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_outputs", int'(ctl != 0 || stride_in != 0 || filter_size != 0), 0);
      check("rst_mid_busy", int'(busy), 0);
      sb.delete();
      job_active = 0;
      wait_active = 0;
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) run_job(vecs[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout got %0d want %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
